// File: rtl/mdu_hilo_iter_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - op encodings carried on the 2-bit op port
//     - FSM state encoding
//     - small helpers decoding the op field
// ---------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULU = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIVU = 2'b10,
    MDU_DIV  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Upper op bit selects divide, lower op bit selects signed arithmetic.
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_hilo_iter_if.sv
// ---------------------------------------------------------------------------
// mdu_hilo_iter_if
//   Request/result bundle between the EX stage and the multiply/divide unit.
//   master : pipeline side (drives start/op/operands/flush/MTHI/MTLO)
//   slave  : unit side (drives busy/done/div_by_zero/hi/lo)
// ---------------------------------------------------------------------------
interface mdu_hilo_iter_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mdu_hilo_iter_step.sv
// ---------------------------------------------------------------------------
// mdu_step
//   One iteration of the multiply/divide datapath (purely combinational).
//
//   Ports:
//     div_mode  in   1        1 = restoring-divide step, 0 = shift-add step
//     acc_in    in   2*WIDTH  running accumulator
//     operand   in   WIDTH    multiplicand (multiply) or divisor (divide)
//     acc_out   out  2*WIDTH  accumulator after this iteration
//
//   Multiply layout: {partial_product_hi, remaining_multiplier_bits}.
//     The LSB of the accumulator is the current multiplier bit; the sum is
//     shifted right so the product settles in place after WIDTH steps.
//   Divide layout:   {partial_remainder, remaining_dividend/quotient_bits}.
//     The accumulator shifts left; each quotient bit enters at the LSB, so
//     after WIDTH steps the low half is the quotient and the high half is
//     the remainder.
// ---------------------------------------------------------------------------
module mdu_step #(
  parameter int WIDTH = 16
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // W+1-bit sum keeps the carry so it can shift into the product MSB.
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + (acc_in[0] ? {1'b0, operand} : '0);

    // Partial remainder is always below the divisor, so the shifted trial
    // value fits W+1 bits and the difference, when taken, fits W bits.
    trial   = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    fits    = (trial >= {1'b0, operand});
    diff    = trial - {1'b0, operand};

    if (div_mode) begin
      if (fits) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo_iter.sv
// ---------------------------------------------------------------------------
// mdu_hilo_iter
//   Iterative multiply/divide unit owning the Hi/Lo register pair.
//   An accepted operation takes WIDTH iteration cycles plus one sign-fix
//   cycle; busy is held meanwhile so the hazard unit can stall the front end.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rest  in   asynchronous active-low reset
//     bus   slave side of mdu_hilo_iter_if:
//             start/op/src_a/src_b  operation request (sampled in IDLE only)
//             flush                 abort in-flight operation
//             hi_we/lo_we/wdata     MTHI/MTLO writes (honoured in IDLE only)
//             busy                  operation in flight
//             done                  one-cycle pulse on result or div-by-zero
//             div_by_zero           one-cycle pulse coincident with done
//             hi/lo                 Hi and Lo registers
// ---------------------------------------------------------------------------
module mdu_hilo_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rest,
  mdu_hilo_iter_if.slave bus
);

  import mdu_pkg::*;

  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // negate remainder
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    step_acc;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_mag, rem_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // -------------------------------------------------------------------------
  // Operand conditioning: signed ops run on magnitudes. Negating the most
  // negative value yields the same bit pattern, which is its correct
  // unsigned magnitude, so no special case is needed.
  // -------------------------------------------------------------------------
  always_comb begin
    a_neg = is_signed_op(bus.op) & bus.src_a[WIDTH-1];
    b_neg = is_signed_op(bus.op) & bus.src_b[WIDTH-1];
    mag_a = a_neg ? -bus.src_a : bus.src_a;
    mag_b = b_neg ? -bus.src_b : bus.src_b;
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_mode (div_q),
    .acc_in   (acc_q),
    .operand  (opnd_q),
    .acc_out  (step_acc)
  );

  // -------------------------------------------------------------------------
  // Sign correction applied in FIX. Quotient negation truncates toward
  // zero because it is applied to the magnitude quotient; remainder takes
  // the dividend's sign. MIN / -1 wraps back to MIN naturally.
  // -------------------------------------------------------------------------
  always_comb begin
    quo_mag  = acc_q[WIDTH-1:0];
    rem_mag  = acc_q[W2-1:WIDTH];
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -quo_mag : quo_mag;
    rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // MTHI/MTLO land here; a start on the same edge still proceeds and
        // its result overwrites them later.
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;

        if (bus.start && !bus.flush) begin
          if (is_div(bus.op) && (bus.src_b == '0)) begin
            // Flag immediately; Hi/Lo keep their contents.
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d   = CALC;
            busy_d    = 1'b1;
            cnt_d     = CNT_W'(WIDTH);
            div_d     = is_div(bus.op);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (is_div(bus.op)) begin
              acc_d  = {{WIDTH{1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end

      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo_iter.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo_iter
//   Self-checking bench for mdu_hilo_iter at WIDTH=16. Expected results come
//   from directed constants and from a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mdu_hilo_iter;

  import mdu_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rest;
  int   n_checks;
  int   n_fail;

  mdu_hilo_iter_if #(.WIDTH(W)) bus ();

  mdu_hilo_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi, lo} from ordinary integer arithmetic.
  function automatic logic [31:0] model_hilo(input logic [1:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    longint p;
    int     sa, sb, q, r;
    logic [31:0] res;
    res = '0;
    case (op)
      2'b00: begin p = longint'(a) * longint'(b); res = p[31:0]; end
      2'b01: begin p = longint'($signed(a)) * longint'($signed(b)); res = p[31:0]; end
      2'b10: begin q = int'(a) / int'(b); r = int'(a) % int'(b); res = {r[15:0], q[15:0]}; end
      default: begin
        sa = $signed(a); sb = $signed(b);
        q = sa / sb; r = sa % sb;
        res = {r[15:0], q[15:0]};
      end
    endcase
    return res;
  endfunction

  // Launches one operation and measures it; makes no comparisons itself.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt, output bit done_e0, output bit to);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; to = 1'b0;
    done_e0  = bus.done;
    busy_cnt = bus.busy ? 1 : 0;
    while (bus.done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cnt++;
      if (lat > 60) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    n_checks++; if ({bus.hi, bus.lo} !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h want 0000_0000", bus.hi, bus.lo); end
    @(negedge clk); rest = 1'b1;
    $display("reset released");
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, hi, lo;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [9];
    int lat, bc; bit d0, to;
    vecs = '{
      '{MDU_MULU, 16'h1234, 16'h0010, 16'h0001, 16'h2340},
      '{MDU_MUL,  16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1},
      '{MDU_MUL,  16'h8000, 16'h8000, 16'h4000, 16'h0000},
      '{MDU_DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD},
      '{MDU_DIVU, 16'hFFFF, 16'h0003, 16'h0000, 16'h5555},
      '{MDU_MULU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001},
      '{MDU_DIV,  16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD},
      '{MDU_DIV,  16'hFFF8, 16'h0003, 16'hFFFE, 16'hFFFE},
      '{MDU_DIVU, 16'h0007, 16'h0010, 16'h0007, 16'h0000}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, d0, to);
      $display("directed %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d busy=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, lat, bc);
      n_checks++; if (to || lat != 17) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want 17", i, lat); end
      n_checks++; if (bc != 17) begin n_fail++; $display("FAIL dir_busy_cycles[%0d]: got %0d want 17", i, bc); end
      n_checks++; if ({bus.hi, bus.lo} !== {vecs[i].hi, vecs[i].lo}) begin
        n_fail++; $display("FAIL dir_result[%0d]: got %h_%h want %h_%h", i, bus.hi, bus.lo, vecs[i].hi, vecs[i].lo);
      end
      n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dir_dbz[%0d]: got 1 want 0", i); end
      @(posedge clk); #1;
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL dir_done_pulse[%0d]: got done=%b busy=%b want 0/0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; bit d0, to;
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 16'h1357;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 16'hBEEF;
    @(posedge clk); #1; bus.lo_we = 1'b0;
    n_checks++; if ({bus.hi, bus.lo} !== 32'h1357_BEEF) begin n_fail++; $display("FAIL mt_write: got %h_%h want 1357_beef", bus.hi, bus.lo); end
    run_op(MDU_DIVU, 16'h0064, 16'h0000, lat, bc, d0, to);
    $display("divu by zero: done=%b dbz=%b busy=%b hi=%h lo=%h", bus.done, bus.div_by_zero, bus.busy, bus.hi, bus.lo);
    n_checks++; if (to || lat != 0 || d0 !== 1'b1) begin n_fail++; $display("FAIL dz_done: got lat=%0d want done on first edge", lat); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", bus.div_by_zero); end
    n_checks++; if (bus.busy !== 1'b0 || bc != 0) begin n_fail++; $display("FAIL dz_busy: got busy_cycles=%0d want 0", bc); end
    n_checks++; if ({bus.hi, bus.lo} !== 32'h1357_BEEF) begin n_fail++; $display("FAIL dz_hilo: got %h_%h want 1357_beef", bus.hi, bus.lo); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_pulse: got done=%b dbz=%b want 0/0", bus.done, bus.div_by_zero); end
    run_op(MDU_DIV, 16'h8000, 16'h0000, lat, bc, d0, to);
    $display("div by zero: done=%b dbz=%b hi=%h lo=%h", bus.done, bus.div_by_zero, bus.hi, bus.lo);
    n_checks++; if (to || lat != 0 || bus.div_by_zero !== 1'b1 || {bus.hi, bus.lo} !== 32'h1357_BEEF) begin
      n_fail++; $display("FAIL dz_signed: got lat=%0d dbz=%b hilo=%h_%h want 0/1/1357_beef", lat, bus.div_by_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    bit seen_done;
    // Flush during CALC
    @(negedge clk); bus.start = 1'b1; bus.op = MDU_DIVU; bus.src_a = 16'hFFFF; bus.src_b = 16'h0003;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_calc: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc_e6: got busy=%b want 0", bus.busy); end
    seen_done = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.done) seen_done = 1'b1; end
    n_checks++; if (seen_done || {bus.hi, bus.lo} !== 32'h1357_BEEF) begin
      n_fail++; $display("FAIL flush_calc_result: got done_seen=%b hilo=%h_%h want 0/1357_beef", seen_done, bus.hi, bus.lo);
    end
    $display("flush in CALC: hi=%h lo=%h", bus.hi, bus.lo);
    // Flush on the FIX edge
    @(negedge clk); bus.start = 1'b1; bus.op = MDU_MULU; bus.src_a = 16'h0101; bus.src_b = 16'h0202;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.hi, bus.lo} !== 32'h1357_BEEF) begin
      n_fail++; $display("FAIL flush_fix: got done=%b busy=%b hilo=%h_%h want 0/0/1357_beef", bus.done, bus.busy, bus.hi, bus.lo);
    end
    $display("flush in FIX: hi=%h lo=%h", bus.hi, bus.lo);
    // Flush together with start in IDLE drops the start
    @(negedge clk); bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_DIVU; bus.src_a = 16'h0010; bus.src_b = 16'h0000;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL flush_start: got busy=%b done=%b dbz=%b want 0/0/0", bus.busy, bus.done, bus.div_by_zero);
    end
    // Asynchronous reset mid-operation
    @(negedge clk); bus.start = 1'b1; bus.op = MDU_MULU; bus.src_a = 16'h1234; bus.src_b = 16'h0010;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2; rest = 1'b0;
    #1;
    n_checks++; if ({bus.hi, bus.lo} !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got hilo=%h_%h busy=%b done=%b want 0/0/0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    $display("async reset mid-op: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    @(negedge clk); rest = 1'b1;
  endtask

  task automatic test_ignore_while_busy();
    int lat; bit seen_done, seen_busy;
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 16'h2222;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.op = MDU_DIV; bus.src_a = 16'h8000; bus.src_b = 16'hFFFF;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1; bus.start = 1'b1; bus.op = MDU_MULU; bus.src_a = 16'h0005; bus.src_b = 16'h0005;
    @(posedge clk); #1; bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 16'hAAAA;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    n_checks++; if (bus.hi !== 16'h2222 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_hi_we: got hi=%h busy=%b want 2222/1", bus.hi, bus.busy);
    end
    lat = 4;
    while (bus.done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    $display("div min/-1: hi=%h lo=%h dbz=%b lat=%0d", bus.hi, bus.lo, bus.div_by_zero, lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL minneg1_latency: got %0d want 17", lat); end
    n_checks++; if ({bus.hi, bus.lo} !== 32'h0000_8000 || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL minneg1_result: got %h_%h dbz=%b want 0000_8000/0", bus.hi, bus.lo, bus.div_by_zero);
    end
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.done) seen_done = 1'b1; if (bus.busy) seen_busy = 1'b1; end
    n_checks++; if (seen_done || seen_busy) begin
      n_fail++; $display("FAIL no_queue: got done_seen=%b busy_seen=%b want 0/0", seen_done, seen_busy);
    end
  endtask

  task automatic test_write_with_start();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULU; bus.src_a = 16'h0003; bus.src_b = 16'h0007;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 16'h5A5A;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    n_checks++; if ({bus.hi, bus.lo} !== 32'h5A5A_5A5A || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL start_write: got %h_%h busy=%b want 5a5a_5a5a/1", bus.hi, bus.lo, bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    $display("start+mt write: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    n_checks++; if (lat != 17 || {bus.hi, bus.lo} !== 32'h0000_0015) begin
      n_fail++; $display("FAIL start_write_result: got %h_%h lat=%0d want 0000_0015/17", bus.hi, bus.lo, lat);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [15:0] exp_hi, exp_lo, a, b, wv;
    logic [31:0] r;
    logic [1:0]  op;
    int lat, bc; bit d0, to, dz;
    @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 16'hC0DE;
    @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    exp_hi = 16'hC0DE; exp_lo = 16'hC0DE;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: a = 16'h8000;
        2: b = 16'hFFFF;
        3: b = 16'h0001;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        wv = 16'($urandom);
        @(negedge clk); bus.lo_we = 1'b1; bus.wdata = wv;
        @(posedge clk); #1; bus.lo_we = 1'b0;
        exp_lo = wv;
        n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL rnd_mtlo[%0d]: got %h want %h", i, bus.lo, exp_lo); end
      end
      dz = op[1] && (b == 16'h0000);
      if (!dz) begin
        r = model_hilo(op, a, b);
        exp_hi = r[31:16];
        exp_lo = r[15:0];
      end
      run_op(op, a, b, lat, bc, d0, to);
      $display("txn %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", i, op, a, b, bus.hi, bus.lo, bus.div_by_zero, lat);
      n_checks++; if (to || lat != (dz ? 0 : 17) || d0 !== dz) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: got lat=%0d done_e0=%b want %0d/%b", i, lat, d0, dz ? 0 : 17, dz);
      end
      n_checks++; if (bus.div_by_zero !== dz) begin
        n_fail++; $display("FAIL rnd_dbz[%0d]: got %b want %b", i, bus.div_by_zero, dz);
      end
      n_checks++; if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin
        n_fail++; $display("FAIL rnd_result[%0d]: got %h_%h want %h_%h", i, bus.hi, bus.lo, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rest     = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_flush();
    test_ignore_while_busy();
    test_write_with_start();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
